fifo_stream_reader: RTL and testbench



---
 rtl/fifo_stream_reader.sv | 129 ++++++++++++
 tb/tb_fifo_stream_reader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side engine for the synchronous FIFO: pops words and presents them on a valid/ready stream.
// Optional statistics outputs are enabled by defining FIFO_READER_STATS_EN.
module fifo_stream_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  idle
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [15:0]           word_count,
    output logic                  underrun_seen
`endif
);

    localparam int unsigned BcntW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BcntW-1:0] BcntMax = BcntW'(BURST_LEN - 1);

    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic [1:0]            occ_q, occ_d;
    logic                  in_flight_q, in_flight_d;
    logic [BcntW-1:0]      bcnt_q, bcnt_d;

    logic       pop;
    logic [1:0] pending;

    always_comb begin
        pending    = occ_q + {1'b0, in_flight_q};
        m_valid    = (occ_q != 2'd0);
        m_data     = buf0_q;
        m_last     = m_valid && (bcnt_q == BcntMax);
        pop        = m_valid && m_ready;
        // A read may be issued into a full slot only if the head leaves on this same edge.
        fifo_rd_en = !rst && en && !fifo_empty &&
                     ((pending < 2'd2) || ((pending == 2'd2) && pop));
        idle       = rst || ((occ_q == 2'd0) && !in_flight_q && (!en || fifo_empty));
    end

    always_comb begin
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        occ_d       = occ_q;
        in_flight_d = fifo_rd_en;
        case ({in_flight_q, pop})
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b10: begin
                if (occ_q == 2'd0) begin
                    buf0_d = fifo_dout;
                end else begin
                    buf1_d = fifo_dout;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b11: begin
                // Capture queues behind whatever remains after the head leaves.
                if (occ_q == 2'd1) begin
                    buf0_d = fifo_dout;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = fifo_dout;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        bcnt_d = bcnt_q;
        if (pop) begin
            bcnt_d = (bcnt_q == BcntMax) ? '0 : bcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf0_q      <= '0;
            buf1_q      <= '0;
            occ_q       <= 2'd0;
            in_flight_q <= 1'b0;
            bcnt_q      <= '0;
        end else begin
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            occ_q       <= occ_d;
            in_flight_q <= in_flight_d;
            bcnt_q      <= bcnt_d;
        end
    end

`ifdef FIFO_READER_STATS_EN
    logic [15:0] word_count_q, word_count_d;
    logic        underrun_q, underrun_d;

    always_comb begin
        word_count_d = word_count_q;
        if (pop && (word_count_q != 16'hFFFF)) begin
            word_count_d = word_count_q + 16'd1;
        end
        underrun_d = underrun_q || (en && m_ready && !m_valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_count_q <= 16'd0;
            underrun_q   <= 1'b0;
        end else begin
            word_count_q <= word_count_d;
            underrun_q   <= underrun_d;
        end
    end

    assign word_count    = word_count_q;
    assign underrun_seen = underrun_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: a FIFO model feeds the DUT, a monitor checks the stream.
module tb_fifo_stream_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       m_ready = 1'b0;
    logic       force_ne = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       model_empty = 1'b1;
    logic       dut_empty;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_rd_en, m_valid, m_last, idle;
    logic [7:0] m_data;
`ifdef FIFO_READER_STATS_EN
    logic [15:0] word_count;
    logic        underrun_seen;
`endif

    logic [7:0] fifo_q[$];
    logic [8:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         rd_cnt = 0;
    int         r0;
    logic       stall_q = 1'b0;
    logic [9:0] held_q = '0;
    logic [8:0] e;

    assign dut_empty = model_empty && !force_ne;

    fifo_stream_reader #(.DATA_WIDTH(8), .BURST_LEN(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (dut_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .idle       (idle)
`ifdef FIFO_READER_STATS_EN
        ,
        .word_count   (word_count),
        .underrun_seen(underrun_seen)
`endif
    );

    always #5 clk = ~clk;

    // FIFO model with one-cycle registered read data.
    always @(posedge clk) begin
        if (rst) begin
            fifo_q.delete();
            fifo_dout   <= 8'h00;
            model_empty <= 1'b1;
        end else begin
            if (fifo_rd_en && !dut_empty) fifo_dout <= fifo_q.pop_front();
            if (wr_en) fifo_q.push_back(wr_data);
            model_empty <= (fifo_q.size() == 0);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            checks++;
            if (fifo_rd_en && dut_empty) begin
                errors++;
                $display("FAIL rd_en_on_empty: fifo_rd_en=1 with fifo_empty=1, required 0");
            end
            if (stall_q) begin
                checks++;
                if ({m_valid, m_last, m_data} !== held_q) begin
                    errors++;
                    $display("FAIL stall_hold: got %h required %h", {m_valid, m_last, m_data}, held_q);
                end
            end
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got data=%h last=%b, required none", m_data, m_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_last, m_data} !== e) begin
                        errors++;
                        $display("FAIL stream_word: got last=%b data=%h required last=%b data=%h",
                                 m_last, m_data, e[8], e[7:0]);
                    end
                end
            end
            stall_q = m_valid && !m_ready;
            held_q  = {m_valid, m_last, m_data};
            if (fifo_rd_en) rd_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    task automatic fifo_write(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic expect_word(input logic [7:0] d, input logic last);
        exp_q.push_back({last, d});
    endtask

    task automatic wait_drain(input string name, input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d words undelivered, required 0", name, exp_q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with a non-empty FIFO presented.
        rst = 1'b1; en = 1'b1; force_ne = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge clk);
            check("reset_rd_en", 32'(fifo_rd_en), 32'd0);
            check("reset_m_valid", 32'(m_valid), 32'd0);
            check("reset_idle", 32'(idle), 32'd1);
            check("reset_m_data", 32'(m_data), 32'd0);
        end
        tick();
        rst = 1'b0; force_ne = 1'b0; en = 1'b0;
        @(negedge clk);
        check("post_reset_idle", 32'(idle), 32'd1);

        // Streaming 01..10, m_last every 4th word.
        tick();
        for (int i = 1; i <= 16; i++) begin
            expect_word(8'(i), (i % 4) == 0);
            fifo_write(8'(i));
        end
        en = 1'b1;
        @(negedge clk);
        check("stream_first_rd_en", 32'(fifo_rd_en), 32'd1);
        check("stream_lat0_valid", 32'(m_valid), 32'd0);
        tick();
        @(negedge clk);
        check("stream_lat1_valid", 32'(m_valid), 32'd0);
        tick();
        @(negedge clk);
        check("stream_lat2_valid", 32'(m_valid), 32'd1);
        check("stream_first_data", 32'(m_data), 32'h01);
        repeat (16) tick();
        check("stream_back_to_back", 32'(exp_q.size()), 32'd0);
        check("stream_done_valid", 32'(m_valid), 32'd0);
        check("stream_done_idle", 32'(idle), 32'd1);
        wait_drain("stream_drain", 4);

        // Backpressure: bcnt is 0, three words, no m_last.
        m_ready = 1'b0;
        expect_word(8'hAA, 1'b0);
        expect_word(8'hBB, 1'b0);
        expect_word(8'hCC, 1'b0);
        fifo_write(8'hAA);
        fifo_write(8'hBB);
        fifo_write(8'hCC);
        repeat (5) tick();
        @(negedge clk);
        check("bp_rd_en_low", 32'(fifo_rd_en), 32'd0);
        check("bp_m_valid", 32'(m_valid), 32'd1);
        check("bp_head_data", 32'(m_data), 32'hAA);
        check("bp_fifo_holds_cc", 32'(dut_empty), 32'd0);
        tick();
        m_ready = 1'b1;
        wait_drain("bp_drain", 20);

        // Single word: bcnt is 3, so this word closes the burst.
        r0 = rd_cnt;
        expect_word(8'h5A, 1'b1);
        fifo_write(8'h5A);
        wait_drain("single_drain", 20);
        repeat (2) tick();
        check("single_rd_pulses", 32'(rd_cnt - r0), 32'd1);
        check("single_idle", 32'(idle), 32'd1);

        // en toggling: two reads, gap, resume with burst alignment kept.
        en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            expect_word(8'(8'h21 + i), i == 3);
            fifo_write(8'(8'h21 + i));
        end
        r0 = rd_cnt;
        en = 1'b1;
        tick();
        tick();
        en = 1'b0;
        repeat (6) tick();
        check("en_gap_rd_count", 32'(rd_cnt - r0), 32'd2);
        check("en_gap_delivered", 32'(exp_q.size()), 32'd4);
        check("en_gap_idle", 32'(idle), 32'd1);
        en = 1'b1;
        wait_drain("en_resume_drain", 30);

        // Mid-stream reset with two words buffered; bcnt was 2 before reset.
        m_ready = 1'b0;
        fifo_write(8'h31);
        fifo_write(8'h32);
        fifo_write(8'h33);
        repeat (4) tick();
        check("mid_valid_before_rst", 32'(m_valid), 32'd1);
`ifdef FIFO_READER_STATS_EN
        check("word_count_before_rst", 32'(word_count), 32'd26);
`endif
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 32'(m_valid), 32'd0);
`ifdef FIFO_READER_STATS_EN
        check("mid_rst_word_count", 32'(word_count), 32'd0);
        check("mid_rst_underrun", 32'(underrun_seen), 32'd0);
`endif
        rst = 1'b0;
        m_ready = 1'b1;
        en = 1'b1;
        tick();
        check("post_rst_starved_valid", 32'(m_valid), 32'd0);
`ifdef FIFO_READER_STATS_EN
        check("underrun_sticky", 32'(underrun_seen), 32'd1);
`endif
        for (int i = 0; i < 4; i++) begin
            expect_word(8'(8'h41 + i), i == 3);
            fifo_write(8'(8'h41 + i));
        end
        wait_drain("post_rst_drain", 20);
        repeat (2) tick();
        check("final_idle", 32'(idle), 32'd1);
`ifdef FIFO_READER_STATS_EN
        check("final_word_count", 32'(word_count), 32'd4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
